// File: rtl/vram_arb_pkg.sv
// Shared definitions for the video RAM arbiter: port ids, read-tag layout
// and small helpers used by the arbiter and its round-robin picker.
package vram_arb_pkg;

  // Requester ids carried in the read tag and the round-robin pointer
  localparam logic [1:0] PORT_L0  = 2'd0;
  localparam logic [1:0] PORT_L1  = 2'd1;
  localparam logic [1:0] PORT_SPR = 2'd2;
  localparam logic [1:0] PORT_CPU = 2'd3;

  // Tag captured on every read grant, consumed the following cycle when
  // the RAM returns data for that grant
  typedef struct packed {
    logic       vld;
    logic [1:0] port;
    logic [1:0] lane;
  } rd_tag_t;

  localparam int RD_TAG_W = 5;

  // Byte lane to one-hot write enable, lane 0 = bits 7:0
  function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
    logic [3:0] sel;
    sel = 4'b0000;
    sel[lane] = 1'b1;
    return sel;
  endfunction

  // One-hot video grant {spr, l1, l0} to port id; all-zero maps to L0
  function automatic logic [1:0] vid_port_id(input logic [2:0] onehot);
    logic [1:0] id;
    id = PORT_L0;
    if (onehot[1]) id = PORT_L1;
    if (onehot[2]) id = PORT_SPR;
    return id;
  endfunction

endpackage

// File: rtl/vram_arbiter_rr_pick3.sv
// Three-way round-robin picker: grants the first requester after the one
// that was granted last, searching in the order L0 -> L1 -> SPR -> L0.
module rr_pick3
  import vram_arb_pkg::*;
(
  input  logic [2:0] req_i,   // {spr, l1, l0}
  input  logic [1:0] last_i,  // id of the last granted video port
  output logic [2:0] gnt_o,   // one-hot grant {spr, l1, l0}
  output logic       vld_o
);

  // Fixed-priority search starting just after the last grant
  always_comb begin
    gnt_o = 3'b000;
    case (last_i)
      PORT_L0: begin
        if      (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      PORT_L1: begin
        if      (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      // SPR (and the unused CPU id) hand priority back to L0
      default: begin
        if      (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: one byte-wide CPU port and three 32-bit
// read-only video fetch ports share the RAM, one grant per clock. CPU
// byte accesses become word accesses with a lane select, and read data is
// steered back to whoever was granted in the previous cycle.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 3,
  parameter int AW           = 15
) (
  input  logic          clk,
  input  logic          rst,
  // CPU byte port
  input  logic [AW+1:0] cpu_addr,
  input  logic [7:0]    cpu_wrdata,
  input  logic          cpu_write,
  input  logic          cpu_strobe,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rddata,
  output logic          cpu_rdvalid,
  // Video fetch ports
  input  logic [AW-1:0] l0_addr,
  input  logic [AW-1:0] l1_addr,
  input  logic [AW-1:0] spr_addr,
  input  logic          l0_strobe,
  input  logic          l1_strobe,
  input  logic          spr_strobe,
  output logic          l0_ack,
  output logic          l1_ack,
  output logic          spr_ack,
  output logic [31:0]   vid_rddata,
  output logic          l0_rdvalid,
  output logic          l1_rdvalid,
  output logic          spr_rdvalid,
  // RAM slave interface
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wrdata,
  output logic [3:0]    bus_wrbytesel,
  output logic          bus_write,
  input  logic [31:0]   bus_rddata
);

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  logic [1:0] rr_last_q, rr_last_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  rd_tag_t    tag_q, tag_d;
  logic [7:0] cpu_rddata_q, cpu_rddata_d;

  logic [2:0] vid_req;
  logic [2:0] vid_pick;
  logic       vid_any;
  logic [1:0] vid_id;
  logic       cpu_urgent;
  logic       cpu_gnt;
  logic       vid_gnt;
  logic       rd_live;
  logic [7:0] cpu_lane_byte;

  assign vid_req = {spr_strobe, l1_strobe, l0_strobe};

  rr_pick3 u_pick (
    .req_i  (vid_req),
    .last_i (rr_last_q),
    .gnt_o  (vid_pick),
    .vld_o  (vid_any)
  );

  assign vid_id = vid_port_id(vid_pick);

  // Grant selection: a starved CPU wins, then the video round-robin, then
  // the CPU as a filler; nothing is granted while reset is held
  always_comb begin
    cpu_urgent = cpu_strobe && (wait_cnt_q >= MAX_WAIT);
    cpu_gnt    = 1'b0;
    vid_gnt    = 1'b0;
    if (!rst) begin
      if (cpu_urgent)      cpu_gnt = 1'b1;
      else if (vid_any)    vid_gnt = 1'b1;
      else if (cpu_strobe) cpu_gnt = 1'b1;
    end
  end

  assign cpu_ack = cpu_gnt;
  assign l0_ack  = vid_gnt && vid_pick[0];
  assign l1_ack  = vid_gnt && vid_pick[1];
  assign spr_ack = vid_gnt && vid_pick[2];

  // RAM bus drive: idle parks on the layer0 address with writes disabled
  always_comb begin
    bus_addr      = l0_addr;
    bus_wrdata    = {4{cpu_wrdata}};
    bus_wrbytesel = 4'b0000;
    bus_write     = 1'b0;
    if (cpu_gnt) begin
      bus_addr      = cpu_addr[AW+1:2];
      bus_wrbytesel = lane_onehot(cpu_addr[1:0]);
      bus_write     = cpu_write;
    end else if (vid_gnt) begin
      case (vid_id)
        PORT_L1:  bus_addr = l1_addr;
        PORT_SPR: bus_addr = spr_addr;
        default:  bus_addr = l0_addr;
      endcase
    end
  end

  // Next state for pointer, starvation counter and read tag
  always_comb begin
    rr_last_d = vid_gnt ? vid_id : rr_last_q;

    wait_cnt_d = wait_cnt_q;
    if (!cpu_strobe || cpu_gnt)  wait_cnt_d = 4'd0;
    else if (wait_cnt_q != 4'hF) wait_cnt_d = wait_cnt_q + 4'd1;

    tag_d.vld  = (cpu_gnt && !cpu_write) || vid_gnt;
    tag_d.port = cpu_gnt ? PORT_CPU : vid_id;
    tag_d.lane = cpu_addr[1:0];
  end

  // Read return: data for last cycle's read grant is on bus_rddata now;
  // a reset in this cycle suppresses the return entirely
  always_comb begin
    rd_live       = tag_q.vld && !rst;
    l0_rdvalid    = rd_live && (tag_q.port == PORT_L0);
    l1_rdvalid    = rd_live && (tag_q.port == PORT_L1);
    spr_rdvalid   = rd_live && (tag_q.port == PORT_SPR);
    cpu_rdvalid   = rd_live && (tag_q.port == PORT_CPU);
    cpu_lane_byte = bus_rddata[{tag_q.lane, 3'b000} +: 8];
    cpu_rddata_d  = cpu_rdvalid ? cpu_lane_byte : cpu_rddata_q;
  end

  assign vid_rddata = bus_rddata;
  // The returning byte is visible in its rdvalid cycle and held afterwards
  assign cpu_rddata = cpu_rddata_d;

  // State registers; the pointer resets to SPR so layer0 is served first
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q    <= PORT_SPR;
      wait_cnt_q   <= 4'd0;
      tag_q        <= '0;
      cpu_rddata_q <= 8'h00;
    end else begin
      rr_last_q    <= rr_last_d;
      wait_cnt_q   <= wait_cnt_d;
      tag_q        <= tag_d;
      cpu_rddata_q <= cpu_rddata_d;
    end
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sits directly upstream of the 32-bit single-port video RAM. Drives its bus_addr / bus_wrdata / bus_wrbytesel / bus_write slave interface and consumes its bus_rddata, which is valid one cycle after the address.
- Arbitrates one byte-wide host (CPU) port and three 32-bit read-only video fetch ports (layer0, layer1, sprite), with one grant per clock.
- Converts CPU byte accesses into word accesses with byte-lane select and routes returned read data back to the requester that was granted.

Parameters:
- CPU_MAX_WAIT, 3: cycles a pending CPU request may be refused before it preempts all video ports (legal range 1..15).
- AW, 15: word address width of the RAM bus (32K words = 128 KB).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  AW+2  byte address
- cpu_wrdata  in  8  write byte
- cpu_write  in  1  1 = write, 0 = read
- cpu_strobe  in  1  request; held until cpu_ack
- cpu_ack  out  1  request accepted this cycle (combinational)
- cpu_rddata  out  8  read byte; held until the next CPU read returns
- cpu_rdvalid  out  1  cpu_rddata updated this cycle
- l0_addr, l1_addr, spr_addr  in  AW  word addresses
- l0_strobe, l1_strobe, spr_strobe  in  1  read requests; held until ack
- l0_ack, l1_ack, spr_ack  out  1  accepted this cycle (combinational)
- vid_rddata  out  32  shared read data (bus_rddata passthrough)
- l0_rdvalid, l1_rdvalid, spr_rdvalid  out  1  vid_rddata belongs to this port this cycle
- bus_addr  out  AW  RAM word address
- bus_wrdata  out  32  RAM write data
- bus_wrbytesel  out  4  RAM byte-lane write enables
- bus_write  out  1  RAM write enable
- bus_rddata  in  32  RAM read data, valid one cycle after address

Behaviour:
- Reset: all acks and rdvalids 0; bus_write 0; cpu_rddata 0x00; round-robin pointer set so layer0 is the next video port; CPU wait counter 0; any in-flight read tag is discarded. While rst is high, no grants are issued.
- Grant selection (combinational, one per cycle):
  - If cpu_strobe is high and wait_cnt >= CPU_MAX_WAIT, the CPU is granted.
  - Otherwise, the first strobing video port in round-robin order after the last granted video port is granted.
  - Otherwise, if cpu_strobe is high, the CPU is granted.
- The granted port's ack is asserted the same cycle. The requester may present a new request the next cycle, so back-to-back grants to one port are legal.
- Round-robin pointer: updates only when a video port is granted. A CPU grant leaves it unchanged.
- wait_cnt: increments (saturating at 15) each cycle cpu_strobe is high and the CPU is not granted. Cleared on a CPU grant or when cpu_strobe is low.
- Bus outputs:
  - Idle: bus_addr = layer0 address, bus_write 0, bus_wrbytesel 0.
  - Video grant: bus_addr = that port's address, bus_write 0.
  - CPU grant: bus_addr = cpu_addr[AW+1:2]; bus_wrbytesel = one-hot of cpu_addr[1:0] (lane 0 = bits 7:0); bus_wrdata = cpu_wrdata replicated 4x; bus_write = cpu_write.
- Read tag register: captures {valid, port id, byte lane} on every read grant. In the following cycle:
  - The matching rdvalid is 1.
  - vid_rddata = bus_rddata.
  - For a CPU read, the selected lane is registered into cpu_rddata and cpu_rdvalid pulses in that same cycle (cpu_rddata is a registered copy, stable from the next cycle).
  - Writes produce no rdvalid.
- Ordering: a read granted the cycle after a write to the same word returns the written data.
- Reset while a read is in flight: no rdvalid is produced.

Decomposition:
- Package vram_arb_pkg: 2-bit port id constants (PORT_L0, PORT_L1, PORT_SPR, PORT_CPU) and the read-tag struct width constant.
- Sub-module rr_pick3: 3-request round-robin picker. Inputs are the request vector and last-grant id; outputs are a one-hot grant and a valid flag.

Test Plan:
- CPU write 0xA5 to byte address 0x00006, then CPU read of 0x00006 -> write cycle shows bus_addr=1, bus_wrbytesel=4'b0100, bus_wrdata=0xA5A5A5A5; read returns cpu_rddata=0xA5 with cpu_rdvalid exactly 1 cycle after cpu_ack.
- l0, l1 and spr all strobing continuously -> grants rotate L0, L1, SPR, L0, ...; each rdvalid follows its ack by 1 cycle; vid_rddata matches the preloaded word.
- All three video ports plus the CPU strobing, CPU_MAX_WAIT=3 -> CPU refused for 3 cycles and granted on the 4th; video rotation resumes from where it stopped.
- Reset asserted the cycle after an l1 read grant -> l1_rdvalid stays 0; after reset the first video grant goes to layer0.
- CPU read of byte address 0x1FFFF, with word 0x7FFF preloaded to 0xDEADBEEF -> bus_addr=0x7FFF; cpu_rddata=0xDE.
- Single port l0 strobing every cycle for 8 cycles -> 8 consecutive acks and 8 consecutive rdvalids, with no idle bubbles.
